// File: rtl/bitstream_loader.sv
// rtl/bitstream_loader.sv - buffers a byte-stream bitstream, then shifts it gap-free into the config chain.
// Optional chain echo verification pass enabled by defining PROG_VERIFY_EN.
module bitstream_loader #(
  parameter int CHAIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int TOT    = NBYTES * 8;
  localparam int IW     = $clog2(TOT);
  localparam int CW     = $clog2(CHAIN_LEN + 1);
  localparam int BW     = $clog2(NBYTES + 1);

`ifdef PROG_VERIFY_EN
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, VERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

  state_t          state;
  logic [TOT-1:0]  bitbuf;
  logic [TOT-1:0]  buf_next;
  logic [CW-1:0]   bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic            last_bit;
  logic            nxt_bit;

  // Bytes shift in from the bottom, so byte 0's MSB ends up at the top: stream bit k lives at TOT-1-k.
  assign buf_next = (bitbuf << 8) | TOT'(s_data);
  assign nxt_bit  = bitbuf[IW'(TOT - 2) - IW'(bit_cnt)];
  assign last_bit = (bit_cnt == CW'(CHAIN_LEN - 1));
  assign s_ready  = (state == LOAD);

`ifdef PROG_VERIFY_EN
  logic cur_bit;
  assign cur_bit = bitbuf[IW'(TOT - 1) - IW'(bit_cnt)];
`else
  logic unused_prog_out;
  assign unused_prog_out = prog_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bitbuf   <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      prog_en  <= 1'b0;
      prog_in  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        prog_en <= 1'b0;
        prog_in <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= LOAD;
              busy     <= 1'b1;
              err      <= 1'b0;
              byte_cnt <= '0;
            end
          end
          LOAD: begin
            if (s_valid) begin
              bitbuf   <= buf_next;
              byte_cnt <= byte_cnt + BW'(1);
              // First serial bit is registered on the accepting edge so the burst starts next cycle.
              if (byte_cnt == BW'(NBYTES - 1)) begin
                state   <= SHIFT;
                bit_cnt <= '0;
                prog_en <= 1'b1;
                prog_in <= buf_next[TOT-1];
              end
            end
          end
          SHIFT: begin
            if (last_bit) begin
`ifdef PROG_VERIFY_EN
              state   <= VERIFY;
              bit_cnt <= '0;
              prog_in <= bitbuf[TOT-1];
`else
              state   <= IDLE;
              prog_en <= 1'b0;
              prog_in <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
`endif
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              prog_in <= nxt_bit;
            end
          end
`ifdef PROG_VERIFY_EN
          VERIFY: begin
            if (prog_out != cur_bit) err <= 1'b1;
            if (last_bit) begin
              state   <= IDLE;
              prog_en <= 1'b0;
              prog_in <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
              prog_in <= nxt_bit;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitstream_loader.sv
// tb/tb_bitstream_loader.sv - scoreboard bench for bitstream_loader with a 12-bit chain model.
module tb_bitstream_loader;

  localparam int CHAIN_LEN = 12;
`ifdef PROG_VERIFY_EN
  localparam int PASSES = 2;
  localparam logic FLIP_ERR = 1'b1;
`else
  localparam int PASSES = 1;
  localparam logic FLIP_ERR = 1'b0;
`endif
  localparam logic [11:0] PAT = 12'b1010_0101_0011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       prog_en;
  logic       prog_in;
  logic       prog_out;
  logic       busy;
  logic       done;
  logic       err;

  bitstream_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .prog_en(prog_en), .prog_in(prog_in), .prog_out(prog_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Chain model: shifts on prog_en, tail echoes on prog_out; flip corrupts the echo.
  logic [11:0] chain = '0;
  logic        flip = 1'b0;
  always @(posedge clk) if (prog_en) chain <= {chain[10:0], prog_in};
  assign prog_out = chain[11] ^ flip;

  int   n_checks = 0;
  int   n_pass = 0;
  int   en_cnt = 0;
  int   rises = 0;
  logic prev_en = 1'b0;
  logic exp_bits[$];
  logic exp_err[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expected serial bits and done/err events as the DUT presents them.
  always @(negedge clk) begin
    if (prog_en) begin
      en_cnt++;
      if (!prev_en) rises++;
      if (exp_bits.size() == 0) check("unexpected_prog_en", 1, 0);
      else check("prog_in", prog_in, exp_bits.pop_front());
    end
    if (done) begin
      check("prog_en_low_at_done", prog_en, 0);
      if (exp_err.size() == 0) check("unexpected_done", 1, 0);
      else check("err_at_done", err, exp_err.pop_front());
    end
    prev_en = prog_en;
  end

  task automatic push_burst(input logic e);
    logic [11:0] pat;
    pat = PAT;
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < CHAIN_LEN; i++) exp_bits.push_back(pat[11-i]);
    exp_err.push_back(e);
  endtask

  task automatic start_load(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("s_ready_in_load", s_ready, 1);
    check("busy_in_load", busy, 1);
    s_valid = 1'b1; s_data = b0;
    @(posedge clk); #1 s_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("prog_en_low_in_gap", prog_en, 0);
      check("s_ready_in_gap", s_ready, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = b1;
    @(posedge clk); #1 s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic run_full(input string tag, input int gap, input logic e);
    en_cnt = 0; rises = 0;
    push_burst(e);
    start_load(8'hA5, 8'h3F, gap);
    wait_done();
    check({tag, "_en_cycles"}, en_cnt, CHAIN_LEN * PASSES);
    check({tag, "_contiguous"}, rises, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_prog_en", prog_en, 0);
    check("rst_prog_in", prog_in, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // T1 / T2: back-to-back bytes, then a 5-cycle gap between bytes
    run_full("t1", 0, 1'b0);
    run_full("t2", 5, 1'b0);

    // T3: abort in shift cycle 4
    en_cnt = 0; rises = 0;
    push_burst(1'b0);
    start_load(8'hA5, 8'h3F, 0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t3_prog_en_after_abort", prog_en, 0);
    check("t3_busy_after_abort", busy, 0);
    check("t3_done_after_abort", done, 0);
    check("t3_bits_emitted", en_cnt, 5);
    check("t3_bits_left", exp_bits.size(), CHAIN_LEN * PASSES - 5);
    exp_bits.delete();
    exp_err.delete();
    repeat (5) @(negedge clk);
    run_full("t3_reload", 0, 1'b0);

    // T4: reset during LOAD after one byte
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5;
    @(posedge clk); #1 s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t4_s_ready", s_ready, 0);
    check("t4_busy", busy, 0);
    check("t4_prog_en", prog_en, 0);
    check("t4_prog_in", prog_in, 0);
    check("t4_done", done, 0);
    check("t4_err", err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_full("t4_reload", 2, 1'b0);

    // T5: corrupted chain echo, then a clean run clears err
    flip = 1'b1;
    run_full("t5_bad", 0, FLIP_ERR);
    flip = 1'b0;
    run_full("t5_good", 0, 1'b0);

    // T6: start pulsed during SHIFT, then s_valid held in IDLE
    en_cnt = 0; rises = 0;
    push_burst(1'b0);
    start_load(8'hA5, 8'h3F, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    check("t6_en_cycles", en_cnt, CHAIN_LEN * PASSES);
    check("t6_contiguous", rises, 1);
    s_valid = 1'b1; s_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_s_ready_idle", s_ready, 0);
      check("t6_busy_idle", busy, 0);
    end
    @(posedge clk); #1 s_valid = 1'b0;
    run_full("t6_reload", 0, 1'b0);

    repeat (3) @(negedge clk);
    check("bits_queue_empty", exp_bits.size(), 0);
    check("done_queue_empty", exp_err.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
